// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer for the 100 kHz always-on domain: OTP reset, rstz, otp_rdy, reset_timer_done in order.
// All outputs registered; stage delays are counted in clk_osc_100k cycles, soft_reset re-runs from S_OTP_RST.
module por_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int PRE_DLY     = 4,
  parameter int OTP_RST_DLY = 3,
  parameter int OTP_MIN_DLY = 6,
  parameter int OTP_TIMEOUT = 32,
  parameter int TIMER_DLY   = 13,
  parameter int CNT_W       = 8
) (
  input  logic       clk_osc_100k,
  input  logic       porz,
  input  logic       soft_reset,
  input  logic       otp_load_done,
  output logic       rst_otp,
  output logic       rstz_i2c_reg,
  output logic       rstz_otp_100k,
  output logic       otp_rdy,
  output logic       reset_timer_done,
  output logic       otp_err,
  output logic [2:0] seq_state
);
  typedef enum logic [2:0] {
    S_PRE      = 3'd0,
    S_OTP_RST  = 3'd1,
    S_OTP_LOAD = 3'd2,
    S_TIMER    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(OTP_RST_DLY - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(OTP_MIN_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(OTP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(TIMER_DLY - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_n;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   load_seen, load_seen_nxt;
  logic                   load_ok, load_tmo;
  logic                   rstz_q;
  logic                   rst_otp_nxt, rstz_nxt, otp_rdy_nxt, otp_err_nxt, timer_done_nxt;

  // porz asserts asynchronously through the synchroniser, releases after SYNC_STAGES edges
  always_ff @(posedge clk_osc_100k or negedge porz) begin
    if (!porz) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_n = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_osc_100k or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_PRE;
      cnt              <= '0;
      load_seen        <= 1'b0;
      rst_otp          <= 1'b0;
      rstz_q           <= 1'b0;
      otp_rdy          <= 1'b0;
      otp_err          <= 1'b0;
      reset_timer_done <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      load_seen        <= load_seen_nxt;
      rst_otp          <= rst_otp_nxt;
      rstz_q           <= rstz_nxt;
      otp_rdy          <= otp_rdy_nxt;
      otp_err          <= otp_err_nxt;
      reset_timer_done <= timer_done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    load_ok   = 1'b0;
    load_tmo  = 1'b0;
    if (soft_reset && state != S_PRE) begin
      state_nxt = S_OTP_RST;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_PRE:     if (cnt == PRE_LAST) state_nxt = S_OTP_RST;
        S_OTP_RST: if (cnt == RST_LAST) state_nxt = S_OTP_LOAD;
        S_OTP_LOAD: begin
          // a done arriving on the timeout cycle still counts as a good load
          if (cnt >= MIN_LAST && (load_seen || otp_load_done)) begin
            state_nxt = S_TIMER;
            load_ok   = 1'b1;
          end else if (cnt == TMO_LAST) begin
            state_nxt = S_TIMER;
            load_tmo  = 1'b1;
          end
        end
        S_TIMER:   if (cnt == TMR_LAST) state_nxt = S_DONE;
        S_DONE:    cnt_nxt = cnt;
        default:   state_nxt = S_PRE;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
    end
  end

  always_comb begin
    load_seen_nxt  = (state == S_OTP_LOAD) && (state_nxt == S_OTP_LOAD) &&
                     (load_seen || otp_load_done);
    rst_otp_nxt    = (state_nxt != S_PRE);
    rstz_nxt       = (state_nxt == S_OTP_LOAD) || (state_nxt == S_TIMER) || (state_nxt == S_DONE);
    otp_rdy_nxt    = load_ok  || (otp_rdy && (state_nxt == S_TIMER || state_nxt == S_DONE));
    otp_err_nxt    = load_tmo || (otp_err && (state_nxt == S_TIMER || state_nxt == S_DONE));
    timer_done_nxt = (state_nxt == S_DONE);
  end

  assign rstz_i2c_reg  = rstz_q;
  assign rstz_otp_100k = rstz_q;
  assign seq_state     = state;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Two sequencer instances (default timing, all-minimum timing) share stimulus; expected output
// transitions are queued per instance and matched by a monitor whenever the outputs change.
module tb_por_reset_sequencer;
  localparam int NEVER = 1 << 30;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } ev_t;

  // index 0: default parameters, index 1: minimum delays
  localparam int SYNC_D [2] = '{2, 3};
  localparam int PRE_D  [2] = '{4, 1};
  localparam int ORST_D [2] = '{3, 1};
  localparam int MIN_D  [2] = '{6, 1};
  localparam int TMO_D  [2] = '{32, 5};
  localparam int TMR_D  [2] = '{13, 1};

  logic clk_osc_100k;
  logic porz, soft_reset, otp_load_done;
  logic rst_otp_a, rstz_i2c_reg_a, rstz_otp_100k_a, otp_rdy_a, reset_timer_done_a, otp_err_a;
  logic rst_otp_b, rstz_i2c_reg_b, rstz_otp_100k_b, otp_rdy_b, reset_timer_done_b, otp_err_b;
  logic [2:0] seq_state_a, seq_state_b;
  logic [8:0] vec_a, vec_b;
  logic [8:0] prev_v [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int d_lvl = 0;
  int d_pulse = NEVER;
  int s_lo = NEVER;
  int s_hi = NEVER;
  ev_t qa[$];
  ev_t qb[$];

  por_reset_sequencer u_dut_a (
    .clk_osc_100k(clk_osc_100k), .porz(porz), .soft_reset(soft_reset),
    .otp_load_done(otp_load_done), .rst_otp(rst_otp_a), .rstz_i2c_reg(rstz_i2c_reg_a),
    .rstz_otp_100k(rstz_otp_100k_a), .otp_rdy(otp_rdy_a),
    .reset_timer_done(reset_timer_done_a), .otp_err(otp_err_a), .seq_state(seq_state_a)
  );

  por_reset_sequencer #(
    .SYNC_STAGES(3), .PRE_DLY(1), .OTP_RST_DLY(1), .OTP_MIN_DLY(1),
    .OTP_TIMEOUT(5), .TIMER_DLY(1), .CNT_W(4)
  ) u_dut_b (
    .clk_osc_100k(clk_osc_100k), .porz(porz), .soft_reset(soft_reset),
    .otp_load_done(otp_load_done), .rst_otp(rst_otp_b), .rstz_i2c_reg(rstz_i2c_reg_b),
    .rstz_otp_100k(rstz_otp_100k_b), .otp_rdy(otp_rdy_b),
    .reset_timer_done(reset_timer_done_b), .otp_err(otp_err_b), .seq_state(seq_state_b)
  );

  assign vec_a = {seq_state_a, otp_err_a, reset_timer_done_a, otp_rdy_a,
                  rstz_otp_100k_a, rstz_i2c_reg_a, rst_otp_a};
  assign vec_b = {seq_state_b, otp_err_b, reset_timer_done_b, otp_rdy_b,
                  rstz_otp_100k_b, rstz_i2c_reg_b, rst_otp_b};

  initial begin
    clk_osc_100k = 1'b0;
    forever #5 clk_osc_100k = ~clk_osc_100k;
  end

  always @(posedge clk_osc_100k) cyc <= cyc + 1;

  // input driver: levels for cycle cyc are applied mid-cycle
  initial begin
    otp_load_done = 1'b0;
    soft_reset    = 1'b0;
    forever begin
      @(negedge clk_osc_100k);
      otp_load_done = (cyc >= d_lvl) || (cyc == d_pulse);
      soft_reset    = (cyc >= s_lo) && (cyc <= s_hi);
    end
  end

  // ---------------- reference model ----------------
  task automatic push_ev(input int d, input int c, input logic [8:0] v, input int cut);
    ev_t e;
    if (c >= cut) return;
    e.cyc = c;
    e.v   = v;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // outputs from the rstz release cycle onward, given the done waveform
  task automatic rel(input int d, input int trel, input int cut);
    bit         seen;
    bit         ok;
    int         x;
    logic [8:0] v3;
    seen = 1'b0;
    ok   = 1'b0;
    x    = trel + TMO_D[d] - 1;
    for (int c = trel; c < trel + TMO_D[d]; c++) begin
      seen = seen || (c >= d_lvl) || (c == d_pulse);
      if (seen && c >= trel + MIN_D[d] - 1) begin
        x  = c;
        ok = 1'b1;
        break;
      end
    end
    v3 = ok ? {3'd3, 6'b001111} : {3'd3, 6'b100111};
    push_ev(d, trel, {3'd2, 6'b000111}, cut);
    push_ev(d, x + 1, v3, cut);
    push_ev(d, x + 1 + TMR_D[d], {3'd4, v3[5:0] | 6'b010000}, cut);
  endtask

  task automatic boot(input int d, input int t0, input int cut);
    push_ev(d, t0 + PRE_D[d], {3'd1, 6'b000001}, cut);
    rel(d, t0 + PRE_D[d] + ORST_D[d], cut);
  endtask

  // ---------------- monitor ----------------
  task automatic observe(input int d, input logic [8:0] now);
    ev_t e;
    if (now === prev_v[d]) return;
    prev_v[d] = now;
    checks++;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_change dut=%0d cycle=%0d got=%b", d, cyc, now);
      return;
    end
    e = (d == 0) ? qa.pop_front() : qb.pop_front();
    if (e.cyc != cyc || e.v !== now) begin
      errors++;
      $display("FAIL transition dut=%0d got cycle=%0d vec=%b, expected cycle=%0d vec=%b",
               d, cyc, now, e.cyc, e.v);
    end
  endtask

  initial begin
    prev_v[0] = '0;
    prev_v[1] = '0;
    forever begin
      @(negedge clk_osc_100k);
      observe(0, vec_a);
      observe(1, vec_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic porz_drop();
    @(posedge clk_osc_100k);
    #2;
    push_ev(0, cyc, 9'd0, NEVER);
    push_ev(1, cyc, 9'd0, NEVER);
    porz = 1'b0;
    #1;
    checks++;
    if (vec_a !== 9'd0 || vec_b !== 9'd0) begin
      errors++;
      $display("FAIL async_clear got a=%b b=%b expected 0", vec_a, vec_b);
    end
  endtask

  task automatic release_boot(input int cut_rel, input bit pre_soft, input bit use_pulse,
                              input int pk, output int p);
    int cut;
    repeat (3) @(negedge clk_osc_100k);
    checks++;
    if (vec_a !== 9'd0 || vec_b !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got a=%b b=%b expected 0", vec_a, vec_b);
    end
    p   = cyc;
    cut = (cut_rel == NEVER) ? NEVER : p + cut_rel;
    d_pulse = use_pulse ? p + SYNC_D[0] + PRE_D[0] + ORST_D[0] + pk : NEVER;
    if (pre_soft) begin
      s_lo = p + 2;
      s_hi = p + 2;
    end
    boot(0, p + SYNC_D[0], cut);
    boot(1, p + SYNC_D[1], cut);
    porz = 1'b1;
  endtask

  task automatic soft_seq(input int len);
    int s;
    @(negedge clk_osc_100k);
    s = cyc + 2;
    for (int d = 0; d < 2; d++) begin
      push_ev(d, s + 1, {3'd1, 6'b000001}, NEVER);
      rel(d, s + len + ORST_D[d], NEVER);
    end
    s_lo = s;
    s_hi = s + len - 1;
    repeat (len + 70) @(negedge clk_osc_100k);
  endtask

  initial begin
    int p;
    int pk;
    porz = 1'b1;
    #1 porz = 1'b0;

    // done tied high; soft_reset pulse while still in S_PRE is ignored
    d_lvl = 0;
    release_boot(NEVER, 1'b1, 1'b0, 0, p);
    repeat (70) @(negedge clk_osc_100k);

    soft_seq(5);
    soft_seq(int'($urandom_range(1, 6)));

    // porz pulse while the default instance is loading OTP, then a full rerun
    porz_drop();
    pk = int'($urandom_range(9, 14));
    release_boot(pk, 1'b0, 1'b0, 0, p);
    repeat (pk - 1) @(posedge clk_osc_100k);
    porz_drop();
    release_boot(NEVER, 1'b0, 1'b0, 0, p);
    repeat (70) @(negedge clk_osc_100k);

    // single done pulse relative to the default instance's rstz release; last pass never
    d_lvl = NEVER;
    for (int i = 0; i < 4; i++) begin
      porz_drop();
      if (i == 0)      release_boot(NEVER, 1'b0, 1'b1, 10, p);
      else if (i == 3) release_boot(NEVER, 1'b0, 1'b0, 0, p);
      else             release_boot(NEVER, 1'b0, 1'b1, int'($urandom_range(0, 46)) - 6, p);
      repeat (80) @(negedge clk_osc_100k);
    end

    // soft reset out of an errored DONE state clears otp_err
    d_lvl = 0;
    soft_seq(int'($urandom_range(1, 6)));

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL missing_transitions got pending a=%0d b=%0d expected 0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/por_reset_sequencer.md
Name: por_reset_sequencer

Overview:
- Parametrised power-on reset sequencer for the 100 kHz always-on domain.
- Drives the OTP reset, the I2C-register and OTP-domain reset releases, OTP-ready and reset-timer-done, in a fixed order with programmable stage delays.
- Adds over the fixed-timing sequence: an OTP load handshake with minimum delay and timeout, a sticky error flag, soft-reset re-sequencing, and a debug state output.

Parameters:
- SYNC_STAGES, 2, flops in the porz release synchroniser (≥2).
- PRE_DLY, 4, cycles all outputs held low after internal reset release before rst_otp rises (≥1).
- OTP_RST_DLY, 3, cycles rst_otp is high before rstz_i2c_reg/rstz_otp_100k release (≥1).
- OTP_MIN_DLY, 6, minimum cycles from rstz release to otp_rdy (≥1).
- OTP_TIMEOUT, 32, maximum cycles waiting for otp_load_done (≥OTP_MIN_DLY).
- TIMER_DLY, 13, cycles from the otp_rdy stage to reset_timer_done (≥1).
- CNT_W, 8, stage counter width; every delay parameter must be <2^CNT_W.

Ports:
- clk_osc_100k  in  1  free-running 100 kHz clock.
- porz  in  1  power-on reset; asynchronous assert, active-low.
- soft_reset  in  1  synchronous active-high re-sequence request (level).
- otp_load_done  in  1  OTP controller finished loading (level or pulse).
- rst_otp  out  1  OTP macro reset release (high = released).
- rstz_i2c_reg  out  1  I2C register-bank reset, active-low.
- rstz_otp_100k  out  1  OTP-domain reset, active-low.
- otp_rdy  out  1  OTP contents valid.
- reset_timer_done  out  1  boot sequence complete.
- otp_err  out  1  sticky: OTP load timed out.
- seq_state  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset:
  - porz low asynchronously clears all flops; every output is 0 and seq_state = S_PRE.
  - porz release passes through a SYNC_STAGES synchroniser. T0 is the first cycle the internal reset is inactive. Every output is a flop.
- States: S_PRE=0, S_OTP_RST=1, S_OTP_LOAD=2, S_TIMER=3, S_DONE=4. A single counter cnt clears to 0 on every state entry.
- S_PRE: all outputs 0.
  - Exit to S_OTP_RST when cnt = PRE_DLY-1.
  - rst_otp is high from T0+PRE_DLY.
- S_OTP_RST: rst_otp=1, other outputs 0.
  - Exit when cnt = OTP_RST_DLY-1.
  - rstz_i2c_reg and rstz_otp_100k are high together from Trel = T0+PRE_DLY+OTP_RST_DLY.
- S_OTP_LOAD: a sticky load_seen latches otp_load_done.
  - Exit when cnt ≥ OTP_MIN_DLY-1 and (load_seen or otp_load_done). On this exit otp_rdy=1 from the next cycle.
  - If done is already seen, otp_rdy is high at Trel+OTP_MIN_DLY. If done first arrives at Trel+k with k ≥ OTP_MIN_DLY-1, otp_rdy is high at Trel+k+1.
  - Timeout: cnt = OTP_TIMEOUT-1 with no done → go to S_TIMER with otp_err=1 and otp_rdy held 0. If done arrives in that same cycle, done wins (no error).
- S_TIMER: exit when cnt = TIMER_DLY-1. reset_timer_done is high TIMER_DLY cycles after S_TIMER entry.
- S_DONE: terminal; all asserted outputs hold. otp_load_done is ignored outside S_OTP_LOAD.
- soft_reset high, sampled in any state other than S_PRE:
  - Next cycle: rstz_i2c_reg, rstz_otp_100k, otp_rdy, reset_timer_done and otp_err go to 0; load_seen clears; rst_otp stays 1.
  - FSM holds in S_OTP_RST with cnt=0 while soft_reset is high.
  - Sequence resumes from S_OTP_RST on the first low sample, so rstz release comes OTP_RST_DLY cycles after soft_reset falls.
  - In S_PRE, soft_reset is ignored.
- porz asserted mid-sequence: immediate asynchronous return to reset values; the full sequence reruns.
- Monotonic ordering, holding between soft_reset/porz events:
  - rst_otp ≤ rstz_* ≤ reset_timer_done in time.
  - otp_rdy implies rstz_* = 1.
  - reset_timer_done implies rstz_* = 1.

Test Plan:
- Defaults, otp_load_done tied high:
  - rst_otp rises at T0+4, rstz_* at T0+7, otp_rdy at T0+13, reset_timer_done at T0+26.
  - Each intermediate interval is stable; otp_err=0.
- otp_load_done pulses once at Trel+10:
  - otp_rdy rises at Trel+11, reset_timer_done at Trel+24, otp_err=0.
- otp_load_done never asserted:
  - At Trel+32 otp_err=1 and otp_rdy=0; reset_timer_done rises at Trel+45.
- soft_reset held high 5 cycles while in S_DONE:
  - Next cycle rstz_*, otp_rdy and reset_timer_done go to 0, rst_otp stays 1.
  - rstz_* rise 3 cycles after soft_reset falls; reset_timer_done follows after the OTP_MIN_DLY and TIMER_DLY stages.
- porz pulsed low during S_OTP_LOAD:
  - All outputs go to 0 asynchronously, without waiting for a clock edge.
  - On release the full timing of scenario 1 repeats from the new T0.
- PRE_DLY=1, OTP_RST_DLY=1, OTP_MIN_DLY=1, TIMER_DLY=1, done high:
  - Outputs rise on consecutive cycles T0+1, T0+2, T0+3, T0+4.
